// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the direct-mapped instruction cache.
// slave = cache view; master = datapath/memory-controller view.
interface icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [15:0] misscount;

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr, misscount
  );

  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr, misscount
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped read-only I-cache: 0-cycle hits, single-word fill on miss (>= 2 cycles).
// Fetch stalls via ihit=0 until the fill lands; memory backpressure via iwait holds FETCH.
module icache #(
  parameter int SETS  = 16,
  parameter int IDX_W = $clog2(SETS)
) (
  input logic     CLK,
  input logic     nRST,
  icache_if.slave cif
);
  localparam int TAG_W = 30 - IDX_W;

  typedef logic [31:0] word_t;
  typedef enum logic {IDLE, FETCH} state_t;

  state_t           state, next_state;
  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tags [SETS];
  word_t            data [SETS];
  word_t            missaddr;
  logic [15:0]      misscount;

  logic [IDX_W-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0] req_tag, fill_tag;
  logic             hit;
  logic             miss_start;
  logic             fill_en;
  logic             unused_offset;

  assign req_idx  = cif.imemaddr[IDX_W+1:2];
  assign req_tag  = cif.imemaddr[31:IDX_W+2];
  assign fill_idx = missaddr[IDX_W+1:2];
  assign fill_tag = missaddr[31:IDX_W+2];
  assign hit      = valid[req_idx] && (tags[req_idx] == req_tag);

  // Byte offset is irrelevant to a word-granular cache.
  assign unused_offset = ^cif.imemaddr[1:0];

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= IDLE;
      valid     <= '0;
      missaddr  <= '0;
      misscount <= '0;
    end else begin
      state <= next_state;
      if (miss_start) missaddr <= {cif.imemaddr[31:2], 2'b00};
      if (fill_en) begin
        valid[fill_idx] <= 1'b1;
        misscount       <= misscount + 16'd1;
      end
    end
  end

  // Frame payload needs no reset; the valid bits guard it.
  always_ff @(posedge CLK) begin
    if (nRST && fill_en) begin
      tags[fill_idx] <= fill_tag;
      data[fill_idx] <= cif.iload;
    end
  end

  always_comb begin
    next_state   = state;
    miss_start   = 1'b0;
    fill_en      = 1'b0;
    cif.ihit     = 1'b0;
    cif.imemload = '0;
    cif.iREN     = 1'b0;
    cif.iaddr    = '0;
    unique case (state)
      IDLE: begin
        if (cif.imemREN) begin
          if (hit) begin
            cif.ihit     = 1'b1;
            cif.imemload = data[req_idx];
          end else begin
            miss_start = 1'b1;
            next_state = FETCH;
          end
        end
      end
      FETCH: begin
        // A redirect here is ignored; the fill always completes to missaddr.
        cif.iREN  = 1'b1;
        cif.iaddr = missaddr;
        if (!cif.iwait) begin
          fill_en    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign cif.misscount = misscount;
endmodule
